// File: rtl/uart_send_fifo.sv
// Parametrised UART transmitter with a valid/ready input handshake and TX FIFO.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
module uart_send_fifo #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned UART_BPS   = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst,
  input  logic                            tx_valid,
  input  logic [DATA_BITS-1:0]            tx_data,
  output logic                            tx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            tx_busy,
  output logic                            uart_txd
);

  localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int unsigned CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam int unsigned BIT_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);
  localparam bit          ODD_PAR = (PARITY == 1);

  if (BPS_CNT < 2) begin : g_bad_bps
    $error("uart_send_fifo: CLK_FREQ/UART_BPS must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_send_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_send_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_send_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_send_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     clk_cnt, clk_cnt_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 par_bit, par_nxt;
  logic                 txd_nxt;
  logic                 bit_end_c;
  logic                 start_c;
  logic                 pop_c;
  logic                 push_c;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] head_c;

  assign tx_ready = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign tx_busy  = (state != S_IDLE) | (fifo_level != '0);
  assign push_c   = tx_valid & tx_ready;
  assign head_c   = mem[rd_ptr];

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_c && !pop_c)      fifo_level <= fifo_level + LVL_W'(1);
      else if (!push_c && pop_c) fifo_level <= fifo_level - LVL_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push_c) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      uart_txd <= 1'b1;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else begin
      state    <= state_nxt;
      uart_txd <= txd_nxt;
      clk_cnt  <= clk_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      par_bit  <= par_nxt;
    end
  end

  // Next-state and line output; a pop always starts a new frame on the same edge
  always_comb begin
    state_nxt   = state;
    txd_nxt     = uart_txd;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    par_nxt     = par_bit;
    start_c     = 1'b0;
    pop_c       = 1'b0;
    bit_end_c   = (clk_cnt == CNT_W'(BPS_CNT - 1));

    if (state != S_IDLE) clk_cnt_nxt = bit_end_c ? '0 : clk_cnt + CNT_W'(1);

    case (state)
      S_IDLE: begin
        if (fifo_level != '0) start_c = 1'b1;
      end
      S_START: begin
        if (bit_end_c) begin
          txd_nxt     = shift[0];
          shift_nxt   = shift >> 1;
          bit_cnt_nxt = '0;
          state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_nxt = '0;
            if (PARITY != 0) begin
              txd_nxt   = par_bit;
              state_nxt = S_PARITY;
            end else begin
              txd_nxt   = 1'b1;
              state_nxt = S_STOP;
            end
          end else begin
            txd_nxt     = shift[0];
            shift_nxt   = shift >> 1;
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end_c) begin
          txd_nxt     = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            bit_cnt_nxt = '0;
            if (fifo_level != '0) begin
              start_c = 1'b1;
            end else begin
              txd_nxt   = 1'b1;
              state_nxt = S_IDLE;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        txd_nxt   = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase

    if (start_c) begin
      pop_c       = 1'b1;
      shift_nxt   = head_c;
      par_nxt     = (^head_c) ^ ODD_PAR;
      txd_nxt     = 1'b0;
      clk_cnt_nxt = '0;
      bit_cnt_nxt = '0;
      state_nxt   = S_START;
    end
  end

endmodule
